// File: rtl/fir_sample_feeder_if.sv
// Source-side and FIR-side handshake bundle for the FIR sample feeder.
// The slave modport is the feeder itself; master is the surrounding source/FIR.
interface fir_sample_feeder_if #(
  parameter int InWidth = 16
);
  logic               s_valid;
  logic [InWidth-1:0] s_data;
  logic               s_ready;
  logic               fir_in_valid;
  logic [InWidth-1:0] fir_in_data;
  logic               fir_out_valid;

  modport slave (
    input  s_valid, s_data, fir_out_valid,
    output s_ready, fir_in_valid, fir_in_data
  );

  modport master (
    output s_valid, s_data, fir_out_valid,
    input  s_ready, fir_in_valid, fir_in_data
  );
endinterface

// File: rtl/fir_sample_feeder.sv
// Buffers source samples and feeds them one at a time to a sequential FIR,
// waiting for each completion and flagging a FIR that never completes.
module fir_sample_feeder #(
  parameter int InWidth       = 16,
  parameter int LogDepth      = 4,
  parameter int TimeoutCycles = 80,
  parameter int TimeoutWidth  = 8
) (
  input  logic                clk,
  input  logic                rst,
  fir_sample_feeder_if.slave  bus,
  output logic [LogDepth:0]   level,
  output logic                busy,
  output logic                timeout_err,
  output logic [15:0]         issued_cnt
);
  localparam int Depth = 1 << LogDepth;
  localparam logic [LogDepth:0] Full = (LogDepth+1)'(Depth);
  localparam logic [TimeoutWidth-1:0] WdLast = TimeoutWidth'(TimeoutCycles - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

  state_t                  state_q, state_d;
  logic [InWidth-1:0]      mem [Depth];
  logic [LogDepth-1:0]     wptr, rptr;
  logic [TimeoutWidth-1:0] wdog;
  logic                    ov_prev;
  logic                    push, pop, rise, set_err;

  assign bus.s_ready = (level != Full);
  assign push        = bus.s_valid && bus.s_ready;
  // Pop decision uses the pre-edge level, so a sample written this edge waits one cycle.
  assign pop         = (state_q == IDLE) && (level != '0);
  assign rise        = bus.fir_out_valid && !ov_prev;
  assign busy        = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= bus.s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    set_err = 1'b0;
    case (state_q)
      IDLE:  if (level != '0) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT: begin
        // Completion takes priority over a coincident watchdog expiry.
        if (rise) state_d = GAP;
        else if (wdog == WdLast) begin
          state_d = IDLE;
          set_err = 1'b1;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      ov_prev          <= 1'b0;
      wdog             <= '0;
      timeout_err      <= 1'b0;
      issued_cnt       <= '0;
      bus.fir_in_valid <= 1'b0;
      bus.fir_in_data  <= '0;
    end else begin
      state_q          <= state_d;
      ov_prev          <= bus.fir_out_valid;
      bus.fir_in_valid <= pop;
      if (pop) begin
        bus.fir_in_data <= mem[rptr];
        issued_cnt      <= issued_cnt + 16'd1;
      end
      if (state_q == ISSUE)     wdog <= '0;
      else if (state_q == WAIT) wdog <= wdog + 1'b1;
      if (set_err) timeout_err <= 1'b1;
    end
  end
endmodule
